// File: rtl/fsel_pkg.sv
// fsel_pkg: shared FSM state encoding and mode-count limit for the function selector
package fsel_pkg;
  typedef enum logic [1:0] {ACTIVE = 2'b00, BLANK = 2'b01, ARM = 2'b10} state_e;
  localparam int MAX_MODES = 16;
endpackage

// File: rtl/fsel_edge_detect.sv
// fsel_edge_detect: rising-edge detector (clk, rst, level_i -> rise_o); history resets high so a held input never fires after reset
module fsel_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);
  logic hist_q;
  always_ff @(posedge clk)
    hist_q <= rst ? 1'b1 : level_i;
  assign rise_o = level_i & ~hist_q;
endmodule

// File: rtl/function_selector.sv
// function_selector: button-stepped mode selector routing pulse_x_in/pulse_y_in[mode] to pulse_x/pulse_y with blank+re-arm on switch; drives leds, mode, switching
module function_selector
  import fsel_pkg::*;
#(
  parameter int                   N_MODES      = 4,
  parameter int                   MODE_W       = $clog2(N_MODES),
  parameter int                   DEFAULT_MODE = 0,
  parameter int                   BLANK_CYCLES = 1000,
  parameter logic [MAX_MODES-1:0] Y_MASK       = 16'h0004
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               bt_next,
  input  logic               bt_prev,
  input  logic [N_MODES-1:0] pulse_x_in,
  input  logic [N_MODES-1:0] pulse_y_in,
  output logic               pulse_x,
  output logic               pulse_y,
  output logic [N_MODES-1:0] leds,
  output logic [MODE_W-1:0]  mode,
  output logic               switching
);
  localparam int CW = BLANK_CYCLES < 2 ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [MODE_W-1:0] LAST = MODE_W'(N_MODES - 1);
  localparam logic [MODE_W-1:0] DEF = MODE_W'(DEFAULT_MODE);
  state_e              state_q;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [N_MODES-1:0]  leds_q;
  logic [CW-1:0]       cnt_q;
  logic                px_q, py_q, sw_q;
  logic                rise_n, rise_p, step, px_sel, py_sel;
  fsel_edge_detect u_next (.clk(sysclk), .rst(reset), .level_i(bt_next), .rise_o(rise_n));
  fsel_edge_detect u_prev (.clk(sysclk), .rst(reset), .level_i(bt_prev), .rise_o(rise_p));
  always_comb begin
    step   = rise_n ^ rise_p;
    mode_d = rise_n ? (mode_q == LAST ? '0 : mode_q + 1'b1)
                    : (mode_q == '0 ? LAST : mode_q - 1'b1);
    px_sel = pulse_x_in[mode_q];
    py_sel = Y_MASK[mode_q] & pulse_y_in[mode_q];
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ACTIVE;
      mode_q  <= DEF;
      leds_q  <= N_MODES'(1) << DEFAULT_MODE;
      cnt_q   <= '0;
      px_q    <= 1'b0;
      py_q    <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      case (state_q)
        ACTIVE: begin
          px_q <= px_sel;
          py_q <= py_sel;
          if (step) begin
            mode_q  <= mode_d;
            leds_q  <= N_MODES'(1) << mode_d;
            state_q <= BLANK_CYCLES == 0 ? ARM : BLANK;
            cnt_q   <= CNT_INIT;
            sw_q    <= 1'b1;
          end
        end
        BLANK: begin
          px_q <= 1'b0;
          py_q <= 1'b0;
          if (cnt_q == '0) state_q <= ARM;
          else cnt_q <= cnt_q - 1'b1;
        end
        ARM: begin
          px_q <= 1'b0;
          py_q <= 1'b0;
          if (!px_sel) begin
            state_q <= ACTIVE;
            sw_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= ACTIVE;
          px_q    <= 1'b0;
          py_q    <= 1'b0;
          sw_q    <= 1'b0;
        end
      endcase
    end
  end
  assign pulse_x   = px_q;
  assign pulse_y   = py_q;
  assign leds      = leds_q;
  assign mode      = mode_q;
  assign switching = sw_q;
endmodule
